// File: rtl/ps2_scancode_sequencer.sv
// PS/2 set-2 byte sequencer: folds E0/F0 prefixes into 16-bit scancodes,
// emits make/break/error strobes and tracks held levels for the arrow keys.
module ps2_scancode_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] scancode,
  output logic        make_strobe,
  output logic        break_strobe,
  output logic        err_strobe,
  output logic        left,
  output logic        down,
  output logic        right,
  output logic        up
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [15:0]   code, code_nx;
  logic [3:0]    held, held_nx, hit;
  logic          make_nx, break_nx, err_nx;
  logic          is_e0, is_f0, is_overrun;

  assign is_e0      = (rx_data == 8'hE0);
  assign is_f0      = (rx_data == 8'hF0);
  assign is_overrun = (rx_data == 8'h00) || (rx_data == 8'hFF);

  // Candidate code for the current byte; only latched on a make or break.
  assign code = {((state == EXT) || (state == EXT_BRK)) ? 8'hE0 : 8'h00, rx_data};
  assign hit  = {code == 16'hE075, code == 16'hE074, code == 16'hE072, code == 16'hE06B};

  assign {up, right, down, left} = held;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      scancode     <= '0;
      make_strobe  <= 1'b0;
      break_strobe <= 1'b0;
      err_strobe   <= 1'b0;
      held         <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      scancode     <= code_nx;
      make_strobe  <= make_nx;
      break_strobe <= break_nx;
      err_strobe   <= err_nx;
      held         <= held_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    code_nx  = scancode;
    make_nx  = 1'b0;
    break_nx = 1'b0;
    err_nx   = 1'b0;
    held_nx  = held;

    if (rx_valid) begin
      cnt_nx = '0;
      if (is_overrun) begin
        err_nx   = 1'b1;
        held_nx  = '0;
        state_nx = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (is_e0)      state_nx = EXT;
            else if (is_f0) state_nx = BRK;
            else            make_nx  = 1'b1;
          end
          EXT: begin
            if (is_f0) state_nx = EXT_BRK;
            else if (!is_e0) begin
              make_nx  = 1'b1;
              state_nx = IDLE;
            end
          end
          BRK: begin
            if (is_e0) begin
              err_nx   = 1'b1;
              state_nx = EXT;
            end else if (!is_f0) begin
              break_nx = 1'b1;
              state_nx = IDLE;
            end
          end
          EXT_BRK: begin
            if (is_e0 || is_f0) err_nx   = 1'b1;
            else                break_nx = 1'b1;
            state_nx = IDLE;
          end
          default: state_nx = IDLE;
        endcase
        if (make_nx) begin
          code_nx = code;
          held_nx = held | hit;
        end
        if (break_nx) begin
          code_nx = code;
          held_nx = held & ~hit;
        end
      end
    end else if (state != IDLE) begin
      // Saturating compare: the counter never passes CNT_LAST, so it cannot wrap.
      if (cnt >= CNT_LAST) begin
        err_nx   = 1'b1;
        state_nx = IDLE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Bench for ps2_scancode_sequencer: directed scenarios plus random byte
// streams checked against a prefix-queue reference model.
module tb_ps2_scancode_sequencer;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        resetn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] scancode;
  logic        make_strobe, break_strobe, err_strobe;
  logic        left, down, right, up;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]  pend[$];
  int          idle;
  logic [15:0] m_code;
  logic        m_make, m_brk, m_err;
  logic [3:0]  m_held; // {up, right, down, left}

  logic [22:0] obs;
  assign obs = {scancode, make_strobe, break_strobe, err_strobe, up, right, down, left};

  ps2_scancode_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .scancode(scancode), .make_strobe(make_strobe), .break_strobe(break_strobe),
    .err_strobe(err_strobe), .left(left), .down(down), .right(right), .up(up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] exp_vec();
    return {m_code, m_make, m_brk, m_err, m_held};
  endfunction

  function automatic int arrow_idx(input logic [15:0] c);
    case (c)
      16'hE06B: return 0;
      16'hE072: return 1;
      16'hE074: return 2;
      16'hE075: return 3;
      default:  return -1;
    endcase
  endfunction

  task automatic model_reset();
    pend.delete();
    idle   = 0;
    m_code = '0;
    m_make = 1'b0;
    m_brk  = 1'b0;
    m_err  = 1'b0;
    m_held = '0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    logic has_e0, has_f0;
    int idx;
    m_make = 1'b0;
    m_brk  = 1'b0;
    m_err  = 1'b0;
    has_e0 = 1'b0;
    has_f0 = 1'b0;
    foreach (pend[i]) begin
      if (pend[i] == 8'hE0) has_e0 = 1'b1;
      if (pend[i] == 8'hF0) has_f0 = 1'b1;
    end
    if (v) begin
      idle = 0;
      if (b == 8'h00 || b == 8'hFF) begin
        m_err  = 1'b1;
        m_held = '0;
        pend.delete();
      end else if (b == 8'hE0 || b == 8'hF0) begin
        if (has_e0 && has_f0) begin
          m_err = 1'b1;
          pend.delete();
        end else if (b == 8'hE0 && has_f0) begin
          m_err = 1'b1;
          pend.delete();
          pend.push_back(8'hE0);
        end else if (!(b == 8'hE0 && has_e0) && !(b == 8'hF0 && has_f0)) begin
          pend.push_back(b);
        end
      end else begin
        m_code = {has_e0 ? 8'hE0 : 8'h00, b};
        if (has_f0) m_brk = 1'b1;
        else        m_make = 1'b1;
        idx = arrow_idx(m_code);
        if (idx >= 0) m_held[idx] = !has_f0;
        pend.delete();
      end
    end else if (pend.size() != 0) begin
      idle++;
      if (idle >= TO) begin
        m_err = 1'b1;
        pend.delete();
        idle = 0;
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs settled.
  task automatic tick(input logic v, input logic [7:0] b);
    rx_valid = v;
    rx_data  = b;
    model_step(v, b);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hE0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (obs !== 23'h0) begin
        errors++;
        $display("FAIL reset_outputs: got %h expected %h", obs, 23'h0);
      end
    end
    resetn   = 1'b1;
    rx_valid = 1'b0;
    model_reset();
    tick(1'b1, 8'h6B);
    checks++;
    if ({make_strobe, scancode, left} !== {1'b1, 16'h006B, 1'b0}) begin
      errors++;
      $display("FAIL reset_first_make: got make=%b code=%h left=%b expected make=1 code=006b left=0",
               make_strobe, scancode, left);
    end
  endtask

  task automatic test_ext_make_break();
    tick(1'b1, 8'hE0);
    tick(1'b1, 8'h6B);
    checks++;
    if ({make_strobe, break_strobe, scancode, left} !== {2'b10, 16'hE06B, 1'b1}) begin
      errors++;
      $display("FAIL ext_make: got make=%b brk=%b code=%h left=%b expected 1 0 e06b 1",
               make_strobe, break_strobe, scancode, left);
    end
    tick(1'b1, 8'hE0);
    tick(1'b1, 8'hF0);
    tick(1'b1, 8'h6B);
    checks++;
    if ({make_strobe, break_strobe, scancode, left} !== {2'b01, 16'hE06B, 1'b0}) begin
      errors++;
      $display("FAIL ext_break: got make=%b brk=%b code=%h left=%b expected 0 1 e06b 0",
               make_strobe, break_strobe, scancode, left);
    end
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL ext_model: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_multikey();
    logic [7:0] keys[3] = '{8'h75, 8'h74, 8'h75};
    int nm = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'hE0);
      tick(1'b1, keys[i]);
      if (make_strobe === 1'b1) nm++;
    end
    checks++;
    if (nm != 3 || {up, right} !== 2'b11) begin
      errors++;
      $display("FAIL multikey_make: got makes=%0d up=%b right=%b expected 3 1 1", nm, up, right);
    end
    tick(1'b1, 8'hE0);
    tick(1'b1, 8'hF0);
    tick(1'b1, 8'h74);
    checks++;
    if ({break_strobe, up, right} !== 3'b110) begin
      errors++;
      $display("FAIL multikey_break: got brk=%b up=%b right=%b expected 1 1 0",
               break_strobe, up, right);
    end
    tick(1'b1, 8'hE0);
    tick(1'b1, 8'hF0);
    tick(1'b1, 8'h75);
  endtask

  task automatic test_timeout();
    int early = 0;
    tick(1'b1, 8'hE0);
    for (int i = 1; i < int'(TO); i++) begin
      tick(1'b0, 8'h00);
      if (err_strobe !== 1'b0) early++;
    end
    tick(1'b0, 8'h00);
    checks++;
    if (early != 0 || err_strobe !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: got early=%0d err=%b expected 0 1", early, err_strobe);
    end
    tick(1'b0, 8'h00);
    checks++;
    if (err_strobe !== 1'b0) begin
      errors++;
      $display("FAIL timeout_once: got err=%b expected 0", err_strobe);
    end
    tick(1'b1, 8'h72);
    checks++;
    if ({make_strobe, scancode, down} !== {1'b1, 16'h0072, 1'b0}) begin
      errors++;
      $display("FAIL timeout_next: got make=%b code=%h down=%b expected 1 0072 0",
               make_strobe, scancode, down);
    end
    tick(1'b1, 8'hE0);
    early = 0;
    for (int i = 1; i < int'(TO); i++) begin
      tick(1'b0, 8'h00);
      if (err_strobe !== 1'b0) early++;
    end
    tick(1'b1, 8'h72);
    checks++;
    if (early != 0 || {make_strobe, err_strobe, scancode, down} !== {2'b10, 16'hE072, 1'b1}) begin
      errors++;
      $display("FAIL timeout_boundary: got early=%0d make=%b err=%b code=%h down=%b expected 0 1 0 e072 1",
               early, make_strobe, err_strobe, scancode, down);
    end
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL timeout_model: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_error_bytes();
    tick(1'b1, 8'hE0);
    tick(1'b1, 8'h6B);
    tick(1'b1, 8'hE0);
    tick(1'b1, 8'h75);
    tick(1'b1, 8'hFF);
    checks++;
    if ({err_strobe, up, right, down, left, scancode} !== {5'b10000, 16'hE075}) begin
      errors++;
      $display("FAIL overrun: got err=%b levels=%b%b%b%b code=%h expected 1 0000 e075",
               err_strobe, up, right, down, left, scancode);
    end
    tick(1'b1, 8'hE0);
    tick(1'b1, 8'hF0);
    tick(1'b1, 8'hE0);
    checks++;
    if ({err_strobe, make_strobe, break_strobe} !== 3'b100) begin
      errors++;
      $display("FAIL ext_brk_prefix: got err=%b make=%b brk=%b expected 1 0 0",
               err_strobe, make_strobe, break_strobe);
    end
    tick(1'b1, 8'h72);
    checks++;
    if ({make_strobe, scancode} !== {1'b1, 16'h0072}) begin
      errors++;
      $display("FAIL after_error: got make=%b code=%h expected 1 0072", make_strobe, scancode);
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 8'hE0);
    tick(1'b1, 8'h75);
    tick(1'b1, 8'hE0);
    tick(1'b1, 8'hF0);
    checks++;
    if ({break_strobe, up} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_before: got brk=%b up=%b expected 0 1", break_strobe, up);
    end
    tick(1'b1, 8'h75);
    checks++;
    if ({break_strobe, scancode, up} !== {1'b1, 16'hE075, 1'b0}) begin
      errors++;
      $display("FAIL b2b_break: got brk=%b code=%h up=%b expected 1 e075 0", break_strobe, scancode, up);
    end
    tick(1'b0, 8'h00);
    checks++;
    if (break_strobe !== 1'b0) begin
      errors++;
      $display("FAIL b2b_single_pulse: got brk=%b expected 0", break_strobe);
    end
  endtask

  task automatic test_random();
    logic [7:0] arrows[4] = '{8'h6B, 8'h72, 8'h74, 8'h75};
    logic [7:0] b;
    int r, gap;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r < 5)       b = 8'hE0;
      else if (r < 9)  b = 8'hF0;
      else if (r < 15) b = arrows[$urandom_range(0, 3)];
      else if (r < 16) b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      else             b = 8'($urandom_range(1, 254));
      tick(1'b1, b);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random_byte n=%0d b=%h: got %h expected %h", n, b, obs, exp_vec());
      end
      r = $urandom_range(0, 9);
      if (r < 5)      gap = 0;
      else if (r < 9) gap = $urandom_range(1, 5);
      else            gap = $urandom_range(14, 20);
      for (int g = 0; g < gap; g++) begin
        tick(1'b0, 8'($urandom));
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL random_idle n=%0d g=%0d: got %h expected %h", n, g, obs, exp_vec());
        end
      end
    end
  endtask

  initial begin
    resetn   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    test_reset();
    test_ext_make_break();
    test_multikey();
    test_timeout();
    test_error_bytes();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
